// File: rtl/adders_pkg.sv
// Shared adder helpers: operand limits, 3:2 tree depth math and the
// carry-shift convention used by every reduce-n-to-2 compressor.
package adders_pkg;

    localparam int MAX_OPS = 7;

    // Carries move up one bit; the bit shifted past WIDTH-1 is dropped,
    // so c + s always equals the operand sum mod 2^WIDTH.
    localparam int CSA_CARRY_SHL = 1;

    function automatic int csa_next(input int n);
        return n - n / 3;
    endfunction

    function automatic int csa_levels(input int n);
        int m;
        int l;
        m = n;
        l = 0;
        while (m > 2) begin
            m = csa_next(m);
            l++;
        end
        return l;
    endfunction

endpackage

// File: rtl/csa_tree_nbit.sv
// Combinational N-to-2 carry-save reduction built from 3:2 cells.
// Each level groups operands by three; leftovers pass straight down.
module csa_tree_nbit
    import adders_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int N     = 9
) (
    input  logic [N*WIDTH-1:0] i_ops,
    output logic [WIDTH-1:0]   o_c,
    output logic [WIDTH-1:0]   o_s
);

    localparam int LVL  = csa_levels(N);
    localparam int MAXG = (N / 3 > 0) ? N / 3 : 1;

    logic [WIDTH-1:0] w_v  [N];
    logic [WIDTH-1:0] w_gs [MAXG];
    logic [WIDTH-1:0] w_gc [MAXG];

    always_comb begin
        int n;
        int g;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [WIDTH-1:0] c;
        for (int k = 0; k < N; k++) begin
            w_v[k] = i_ops[k*WIDTH +: WIDTH];
        end
        for (int j = 0; j < MAXG; j++) begin
            w_gs[j] = '0;
            w_gc[j] = '0;
        end
        a = '0;
        b = '0;
        c = '0;
        n = N;
        for (int l = 0; l < LVL; l++) begin
            g = n / 3;
            for (int j = 0; j < MAXG; j++) begin
                if (j < g) begin
                    a = w_v[3*j];
                    b = w_v[3*j+1];
                    c = w_v[3*j+2];
                    w_gs[j] = a ^ b ^ c;
                    w_gc[j] = ((a & b) | (a & c) | (b & c)) << CSA_CARRY_SHL;
                end
            end
            // Leftovers move down before group results overwrite low slots.
            for (int r = 0; r < 2; r++) begin
                if (r < n - 3 * g) begin
                    w_v[2*g+r] = w_v[3*g+r];
                end
            end
            for (int j = 0; j < MAXG; j++) begin
                if (j < g) begin
                    w_v[2*j]   = w_gs[j];
                    w_v[2*j+1] = w_gc[j];
                end
            end
            n = 2 * g + (n - 3 * g);
        end
        o_s = w_v[0];
        o_c = w_v[1];
    end

endmodule

// File: rtl/csa_multiop_accum.sv
// Multi-operand modular accumulator: carry-save stage 1 with a beat
// FSM, one CPA in stage 2, valid/ready handshakes on both sides.
module csa_multiop_accum
    import adders_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int NUM_OPS = 7,
    parameter int CNT_W   = 8
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic [NUM_OPS*WIDTH-1:0] i_ops,
    input  logic                     i_first,
    input  logic                     i_last,
    input  logic                     i_valid,
    output logic                     o_ready,
    output logic [WIDTH-1:0]         o_result,
    output logic [CNT_W-1:0]         o_count,
    output logic                     o_valid,
    input  logic                     i_ready
);

    localparam int TN = NUM_OPS + 2;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ACCUM = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [1:0]         r_state;
    logic [WIDTH-1:0]   r_acc_c;
    logic [WIDTH-1:0]   r_acc_s;
    logic [CNT_W-1:0]   r_cnt;
    logic [WIDTH-1:0]   r_result;
    logic [CNT_W-1:0]   r_count;
    logic               r_valid;

    logic               w_open;
    logic               w_s1_valid;
    logic               w_adv2;
    logic               w_accept;
    logic               w_fresh;
    logic [WIDTH-1:0]   w_fb_c;
    logic [WIDTH-1:0]   w_fb_s;
    logic [TN*WIDTH-1:0] w_tree_in;
    logic [WIDTH-1:0]   w_c;
    logic [WIDTH-1:0]   w_s;
    logic [CNT_W-1:0]   w_cnt_next;

    assign w_open     = (r_state == ST_ACCUM);
    assign w_s1_valid = (r_state == ST_DONE);
    assign w_adv2     = w_s1_valid && (!r_valid || i_ready);
    assign o_ready    = !w_s1_valid || w_adv2;
    assign w_accept   = i_valid && o_ready;

    // No open sum means the stale pair must not leak into a new beat.
    assign w_fresh    = i_first || !w_open;
    assign w_fb_c     = w_fresh ? '0 : r_acc_c;
    assign w_fb_s     = w_fresh ? '0 : r_acc_s;
    assign w_tree_in  = {w_fb_s, w_fb_c, i_ops};

    assign w_cnt_next = w_fresh ? CNT_W'(1) :
                        (r_cnt == CNT_MAX) ? r_cnt : r_cnt + CNT_W'(1);

    csa_tree_nbit #(
        .WIDTH (WIDTH),
        .N     (TN)
    ) u_tree (
        .i_ops (w_tree_in),
        .o_c   (w_c),
        .o_s   (w_s)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
            r_acc_c <= '0;
            r_acc_s <= '0;
            r_cnt   <= '0;
        end else if (w_accept) begin
            r_acc_c <= w_c;
            r_acc_s <= w_s;
            r_cnt   <= w_cnt_next;
            r_state <= i_last ? ST_DONE : ST_ACCUM;
        end else if (w_adv2) begin
            r_state <= ST_IDLE;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_result <= '0;
            r_count  <= '0;
            r_valid  <= 1'b0;
        end else if (w_adv2) begin
            r_result <= r_acc_c + r_acc_s;
            r_count  <= r_cnt;
            r_valid  <= 1'b1;
        end else if (i_ready) begin
            r_valid  <= 1'b0;
        end
    end

    assign o_result = r_result;
    assign o_count  = r_count;
    assign o_valid  = r_valid;

endmodule

// File: tb/tb_csa_multiop_accum.sv
// Directed bench for csa_multiop_accum: single and multi-beat sums,
// wrap, backpressure, restart, saturation and reset behaviour.
module tb_csa_multiop_accum;

    logic           clk;
    logic           rst;
    logic [223:0]   ops;
    logic [111:0]   ops16;
    logic           first;
    logic           last;
    logic           vld;
    logic           rdy_in;
    logic           o_ready;
    logic [31:0]    o_result;
    logic [7:0]     o_count;
    logic           o_valid;
    logic           o_ready16;
    logic [15:0]    o_result16;
    logic [7:0]     o_count16;
    logic           o_valid16;

    int total;
    int bad;

    csa_multiop_accum #(.WIDTH(32), .NUM_OPS(7), .CNT_W(8)) dut (
        .i_clk    (clk),
        .i_rst    (rst),
        .i_ops    (ops),
        .i_first  (first),
        .i_last   (last),
        .i_valid  (vld),
        .o_ready  (o_ready),
        .o_result (o_result),
        .o_count  (o_count),
        .o_valid  (o_valid),
        .i_ready  (rdy_in)
    );

    csa_multiop_accum #(.WIDTH(16), .NUM_OPS(7), .CNT_W(8)) dut16 (
        .i_clk    (clk),
        .i_rst    (rst),
        .i_ops    (ops16),
        .i_first  (first),
        .i_last   (last),
        .i_valid  (vld),
        .o_ready  (o_ready16),
        .o_result (o_result16),
        .o_count  (o_count16),
        .o_valid  (o_valid16),
        .i_ready  (rdy_in)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        assert (got === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
        end
    endtask

    function automatic logic [223:0] fill(input logic [31:0] v);
        logic [223:0] r;
        for (int k = 0; k < 7; k++) r[k*32 +: 32] = v;
        return r;
    endfunction

    function automatic logic [223:0] seq17();
        logic [223:0] r;
        for (int k = 0; k < 7; k++) r[k*32 +: 32] = 32'(k + 1);
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic [223:0] v, input logic f,
                        input logic l);
        ops   = v;
        first = f;
        last  = l;
        vld   = 1'b1;
        tick();
        vld   = 1'b0;
        first = 1'b0;
        last  = 1'b0;
    endtask

    task automatic idle(input int n);
        vld = 1'b0;
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        total  = 0;
        bad    = 0;
        rst    = 1'b1;
        ops    = '0;
        ops16  = {7{16'hFFFF}};
        first  = 1'b0;
        last   = 1'b0;
        vld    = 1'b0;
        rdy_in = 1'b1;
        tick();
        tick();
        chk("rst_valid", 32'(o_valid), 0);
        chk("rst_result", o_result, 0);
        chk("rst_count", 32'(o_count), 0);
        rst = 1'b0;
        tick();
        chk("rst_ready", 32'(o_ready), 1);

        // single beat 1..7, also 16-bit wrap on the narrow instance
        beat(seq17(), 1'b1, 1'b1);
        chk("t1_lat_lo", 32'(o_valid), 0);
        tick();
        chk("t1_valid", 32'(o_valid), 1);
        chk("t1_result", o_result, 28);
        chk("t1_count", 32'(o_count), 1);
        chk("w16_result", 32'(o_result16), 32'hFFF9);
        idle(2);
        chk("t1_drain", 32'(o_valid), 0);

        beat(fill(32'hFFFF_FFFF), 1'b1, 1'b1);
        tick();
        chk("wrap_result", o_result, 32'hFFFF_FFF9);
        idle(2);

        // three beats of 255
        beat(fill(32'd255), 1'b1, 1'b0);
        chk("mb_v1", 32'(o_valid), 0);
        beat(fill(32'd255), 1'b0, 1'b0);
        chk("mb_v2", 32'(o_valid), 0);
        beat(fill(32'd255), 1'b0, 1'b1);
        chk("mb_v3", 32'(o_valid), 0);
        tick();
        chk("mb_valid", 32'(o_valid), 1);
        chk("mb_result", o_result, 5355);
        chk("mb_count", 32'(o_count), 3);
        idle(2);

        // backpressure
        rdy_in = 1'b0;
        beat(fill(32'd123456789), 1'b1, 1'b1);
        chk("bp_rdy_a", 32'(o_ready), 1);
        beat(fill(32'd32767), 1'b1, 1'b1);
        chk("bp_valid", 32'(o_valid), 1);
        chk("bp_res_a", o_result, 864197523);
        chk("bp_stall", 32'(o_ready), 0);
        idle(3);
        chk("bp_hold", o_result, 864197523);
        chk("bp_hold_v", 32'(o_valid), 1);
        chk("bp_stall2", 32'(o_ready), 0);
        rdy_in = 1'b1;
        #1;
        chk("bp_rdy_comb", 32'(o_ready), 1);
        tick();
        chk("bp_valid_b", 32'(o_valid), 1);
        chk("bp_res_b", o_result, 229369);
        tick();
        chk("bp_drain", 32'(o_valid), 0);

        // back-to-back single beats, no bubble
        ops   = seq17();
        first = 1'b1;
        last  = 1'b1;
        vld   = 1'b1;
        tick();
        ops = fill(32'd10);
        chk("b2b_rdy", 32'(o_ready), 1);
        tick();
        vld = 1'b0;
        chk("b2b_r1", o_result, 28);
        tick();
        chk("b2b_v2", 32'(o_valid), 1);
        chk("b2b_r2", o_result, 70);
        idle(2);

        // restart mid-accumulation
        beat(fill(32'd5), 1'b1, 1'b0);
        beat(fill(32'd5), 1'b0, 1'b0);
        beat(seq17(), 1'b1, 1'b0);
        beat(fill(32'd2), 1'b0, 1'b1);
        tick();
        chk("rs_result", o_result, 42);
        chk("rs_count", 32'(o_count), 2);
        idle(2);

        // counter saturation over 300 beats
        beat(fill(32'd1), 1'b1, 1'b0);
        for (int i = 0; i < 298; i++) beat(fill(32'd0), 1'b0, 1'b0);
        beat(fill(32'd1), 1'b0, 1'b1);
        tick();
        chk("sat_count", 32'(o_count), 255);
        chk("sat_result", o_result, 14);
        idle(2);

        // reset with a result pending and a sum open
        rdy_in = 1'b0;
        beat(fill(32'd3), 1'b1, 1'b1);
        beat(fill(32'd4), 1'b1, 1'b0);
        chk("mr_pend", 32'(o_valid), 1);
        rst = 1'b1;
        tick();
        chk("mr_valid", 32'(o_valid), 0);
        chk("mr_result", o_result, 0);
        chk("mr_count", 32'(o_count), 0);
        rst    = 1'b0;
        rdy_in = 1'b1;
        tick();
        chk("mr_quiet", 32'(o_valid), 0);
        beat(seq17(), 1'b1, 1'b1);
        tick();
        chk("mr_result2", o_result, 28);
        chk("mr_count2", 32'(o_count), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/csa_multiop_accum.md
# csa_multiop_accum

Pipelined multi-operand modular adder for the SHA-256 datapath. Each accepted beat supplies NUM_OPS operands. The operands are compressed to carry-save form together with a carry-save accumulator. A single carry-propagate adder runs once per completed sum. Single-beat sums (e.g. T1 = h + Σ1 + Ch + K + W) and multi-beat accumulations share one valid/ready pipeline with full backpressure.

## Interface
Parameters:
- WIDTH, 32 — operand and result width; all arithmetic is mod 2^WIDTH.
- NUM_OPS, 7 — operands per beat; legal range 2..7.
- CNT_W, 8 — width of the beat counter.

Ports:
- i_clk  in  1  — single clock; all state updates on the rising edge.
- i_rst  in  1  — synchronous, active-high reset.
- i_ops  in  NUM_OPS*WIDTH  — operand k occupies bits [k*WIDTH +: WIDTH].
- i_first  in  1  — beat starts a new sum; the accumulator contribution is zero.
- i_last  in  1  — beat closes the sum.
- i_valid  in  1  — beat present.
- o_ready  out  1  — beat accepted when i_valid && o_ready.
- o_result  out  WIDTH  — completed sum mod 2^WIDTH.
- o_count  out  CNT_W  — number of beats folded into o_result; saturates at 2^CNT_W−1.
- o_valid  out  1  — result present.
- i_ready  in  1  — result consumed when o_valid && i_ready.

## Operation
- Stage 1 holds the accumulator: acc_c and acc_s (WIDTH each), cnt, open flag and s1_valid.
  - On accept, the compressor reduces NUM_OPS operands plus (acc_c, acc_s) to a new (c, s).
  - (acc_c, acc_s) is forced to zero when i_first=1 or open=0. A beat arriving with no open sum behaves as first.
  - The carry vector is shifted left by 1 and bit WIDTH is discarded, so the invariant is sum ≡ c + s mod 2^WIDTH.
  - cnt is set to 1 on a first beat, otherwise cnt+1, saturating.
- States of the accumulation FSM:
  - IDLE (open=0, s1_valid=0).
  - ACCUM (open=1): entered on an accepted beat with i_last=0.
  - DONE (s1_valid=1): entered on an accepted beat with i_last=1. open is cleared.
  - DONE returns to IDLE when stage 2 takes the pair.
  - If stage 2 takes the pair and a new beat is accepted in the same cycle, the FSM goes directly to ACCUM or DONE.
- i_first on a beat while in ACCUM discards the open partial sum and restarts. No error is flagged.
- Stage 2: o_result ← s1_c + s1_s (one WIDTH-bit CPA), o_count ← cnt, o_valid set. This happens when s1_valid && (!o_valid || i_ready).
- Handshake:
  - adv2 = s1_valid && (!o_valid || i_ready).
  - o_ready = !s1_valid || adv2. This is a combinational path from i_ready; it is permitted.
  - o_valid is held until i_ready. o_result and o_count stay stable while o_valid && !i_ready.
  - With i_valid=0, stage 1 holds. There is no timeout.
- Reset: o_valid=0, o_result=0, o_count=0, acc_c=acc_s=0, cnt=0, open=0, s1_valid=0. o_ready=1 in the cycle after reset deasserts.
  - Reset mid-accumulation or with a result pending discards all state. Nothing is emitted.

## Timing
- Latency: a last beat accepted at edge N gives o_valid=1 after edge N+1.
- Throughput: one beat per cycle with i_ready held high, including back-to-back single-beat sums.
- Full stall: o_valid=1, i_ready=0 and s1_valid=1 → o_ready=0. Partial beats (i_last=0) are still accepted while s1_valid=0.
- Consume and refill in the same cycle: o_valid stays 1 with the new result, and there is no bubble.

## Structure
- Shared package adders_pkg holds:
  - MAX_OPS=7.
  - A function giving the number of 3:2 levels for an N-operand tree.
  - The carry-shift convention (mod 2^WIDTH, MSB carry dropped), shared with the existing reduce-n-to-2 compressors.
- Sub-module csa_tree_nbit #(WIDTH, N): purely combinational N-to-2 reduction built from 3:2 cells.
  - Instantiated once with N = NUM_OPS+2.
  - Reused by later SHA blocks.
- Top level contains only the stage-1 FSM, the counter, the stage-2 CPA register and the handshake logic.

## Test plan
- Single beat, NUM_OPS=7, ops 1..7, first=last=1 → o_result=28 and o_count=1 one cycle after accept.
- Seven ops of 0xFFFFFFFF → o_result=0xFFFFFFF9 (modular wrap). Same check with WIDTH=16: seven ops of 0xFFFF → 0xFFF9.
- Three beats, every op 255, first on beat 1, last on beat 3 → o_result=5355, o_count=3. o_valid stays low during beats 1–2.
- Backpressure: i_ready=0 for 4 cycles while two single-beat sums arrive (ops 123456789 ×7, then 32767 ×7).
  - Required: first result 864197523 is held stable; o_ready=0 once the second sum completes in stage 1.
  - Required: both results are delivered in order with no loss when i_ready rises.
- Restart: i_first mid-accumulation after beats of value 5 → only the new beats are summed; o_count counts from the restart.
- Reset asserted mid-accumulation and with o_valid=1 → outputs are 0 next cycle; a subsequent single beat 1..7 yields 28.
